cell_tt_checker: RTL and testbench

Self-checking response capture engine for single-output standard-cell models. It is the receiving end of the exhaustive truth-table sweep that our cell benches perform by hand. On `start`, it drives every input combination of an `N_IN`-input cell in ascending binary order and waits a programmable settle time per vector. It then samples the cell output, compares it against an expected truth-table vector and reports pass/fail, mismatch count, first failing index and the captured truth table. It sits beside the cell under test in a bench or in silicon-style BIST wrappers, replacing `$display`-based manual inspection.

---
 rtl/cell_tt_checker_pkg.sv | 25 ++
 rtl/cell_tt_checker_if.sv | 36 +++
 rtl/cell_tt_checker_settle_timer.sv | 35 +++
 rtl/cell_tt_checker.sv | 158 +++++++++++++++
 tb/tb_cell_tt_checker.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cell_tt_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cell_tt_checker_pkg                                  |
// | Description : Shared state encodings, library-cell truth tables    |
// |               and sizing helpers for the cell truth-table checkers |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package cell_tt_checker_pkg;

    // Checker FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_APPLY = 1'b1;

    // Expected truth tables, bit i = output for stim = i, MSB of stim = first pin
    localparam logic [7:0] TT_OAI21 = 8'h1F;  // ZN = !(A & (B1 | B2)), stim = {A,B1,B2}
    localparam logic [7:0] TT_AOI21 = 8'h07;  // ZN = !(A | (B1 & B2)), stim = {A,B1,B2}
    localparam logic [3:0] TT_NAND2 = 4'h7;   // ZN = !(A1 & A2),       stim = {A1,A2}

    // Settle counter width: enough to hold SETTLE, never narrower than one bit
    function automatic int tmr_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_tt_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cell_tt_checker_if                                   |
// | Description : Control, stimulus and result bundle between a cell   |
// |               truth-table checker and its bench / BIST wrapper     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface cell_tt_checker_if #(
    parameter int N_IN = 3
);
    logic                  start;
    logic                  dut_out;
    logic [N_IN-1:0]       stim;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [N_IN:0]         err_cnt;
    logic                  first_err_valid;
    logic [N_IN-1:0]       first_err_idx;
    logic [2**N_IN-1:0]    obs_tt;

    // Bench / wrapper side: launches sweeps and returns the cell output
    modport master (
        output start, dut_out,
        input  stim, busy, done, pass, err_cnt,
               first_err_valid, first_err_idx, obs_tt
    );

    // Checker side
    modport slave (
        input  start, dut_out,
        output stim, busy, done, pass, err_cnt,
               first_err_valid, first_err_idx, obs_tt
    );
endinterface
`default_nettype wire

// File: rtl/cell_tt_checker_settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : settle_timer                                         |
// | Description : Loadable down-counter that stops at zero; flags the  |
// |               sample cycle for the cell truth-table checkers       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module settle_timer #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; otherwise count down while enabled, holding at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cell_tt_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cell_tt_checker                                      |
// | Description : Exhaustive truth-table sweep of a single-output cell |
// |               with settle delay, compare against expected table,   |
// |               and capture of pass / error count / first failure    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module cell_tt_checker
    import cell_tt_checker_pkg::*;
#(
    parameter int                 N_IN   = 3,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXP_TT = 8'h1F
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cell_tt_checker_if.slave   bus
);

    localparam int                  c_TMR_W     = tmr_width(SETTLE);
    localparam logic [c_TMR_W-1:0]  c_SETTLE_LD = c_TMR_W'(SETTLE);
    localparam logic [N_IN-1:0]     c_LAST      = {N_IN{1'b1}};

    // State and result registers
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [N_IN-1:0]     r_stim;
    logic                r_done;
    logic                r_pass;
    logic [N_IN:0]       r_err_cnt;
    logic                r_fev;
    logic [N_IN-1:0]     r_fei;
    logic [2**N_IN-1:0]  r_obs;

    // Decoded controls
    logic                w_accept;
    logic                w_sample;
    logic                w_last;
    logic                w_tmr_load;
    logic                w_tmr_en;
    logic                w_tmr_zero;
    logic                w_busy;

    // Compare path
    logic                w_exp_bit;
    logic                w_mismatch;
    logic                w_obs_bit;
    logic [N_IN:0]       w_err_nxt;

    settle_timer #(
        .WIDTH    (c_TMR_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .en       (w_tmr_en),
        .load_val (c_SETTLE_LD),
        .zero     (w_tmr_zero)
    );

    // Case equality so that X/Z from the cell is a mismatch and reads back as 0
    assign w_exp_bit  = EXP_TT[r_stim];
    assign w_mismatch = (bus.dut_out !== w_exp_bit);
    assign w_obs_bit  = (bus.dut_out === 1'b1);
    assign w_err_nxt  = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: start launches a sweep, the last vector's sample ends it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = ST_APPLY;
            ST_APPLY: if (w_last)    w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: sweep acceptance, sample strobe and settle-timer control
    always_comb begin
        w_accept   = 1'b0;
        w_sample   = 1'b0;
        w_last     = 1'b0;
        w_busy     = 1'b0;
        w_tmr_en   = 1'b0;
        w_tmr_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept   = bus.start;
                w_tmr_load = bus.start;
            end
            ST_APPLY: begin
                w_busy     = 1'b1;
                w_tmr_en   = 1'b1;
                w_sample   = w_tmr_zero;
                w_last     = w_tmr_zero && (r_stim == c_LAST);
                w_tmr_load = w_tmr_zero && (r_stim != c_LAST);
            end
            default: begin
                w_busy     = 1'b0;
            end
        endcase
    end

    // Sweep datapath: clear on accept, capture/compare on each sample strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim    <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_fev     <= 1'b0;
            r_fei     <= '0;
            r_obs     <= '0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_stim    <= '0;
                r_pass    <= 1'b0;
                r_err_cnt <= '0;
                r_fev     <= 1'b0;
                r_fei     <= '0;
                r_obs     <= '0;
            end else if (w_sample) begin
                r_obs[r_stim] <= w_obs_bit;
                r_err_cnt     <= w_err_nxt;
                if (w_mismatch && !r_fev) begin
                    r_fev <= 1'b1;
                    r_fei <= r_stim;
                end
                if (w_last) begin
                    r_pass <= (w_err_nxt == '0);
                end
                // Natural wrap takes stim from the last vector back to 0 for IDLE
                r_stim <= r_stim + 1'b1;
            end
        end
    end

    assign bus.stim            = r_stim;
    assign bus.busy            = w_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_cnt         = r_err_cnt;
    assign bus.first_err_valid = r_fev;
    assign bus.first_err_idx   = r_fei;
    assign bus.obs_tt          = r_obs;

endmodule
`default_nettype wire

// File: tb/tb_cell_tt_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_cell_tt_checker                                   |
// | Description : Self-checking bench for cell_tt_checker: four       |
// |               checker configurations against behavioural cells     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_cell_tt_checker;
    import cell_tt_checker_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // a: defaults; b: wrong expected table; c/d: 1-cycle-late cell, SETTLE 0/1
    cell_tt_checker_if #(.N_IN(3)) if_a ();
    cell_tt_checker_if #(.N_IN(3)) if_b ();
    cell_tt_checker_if #(.N_IN(3)) if_c ();
    cell_tt_checker_if #(.N_IN(3)) if_d ();

    cell_tt_checker u_a (.clk(clk), .rst(rst), .bus(if_a));
    cell_tt_checker #(.N_IN(3), .SETTLE(2), .EXP_TT(8'h3F)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    cell_tt_checker #(.N_IN(3), .SETTLE(0), .EXP_TT(8'h1F)) u_c (.clk(clk), .rst(rst), .bus(if_c));
    cell_tt_checker #(.N_IN(3), .SETTLE(1), .EXP_TT(8'h1F)) u_d (.clk(clk), .rst(rst), .bus(if_d));

    // Behavioural cells
    logic [7:0] resp_a = 8'h1F;
    logic [7:0] oai    = TT_OAI21;
    logic       dly_c, dly_d;

    assign if_a.dut_out = resp_a[if_a.stim];
    assign if_b.dut_out = oai[if_b.stim];
    always @(posedge clk) begin
        dly_c <= oai[if_c.stim];
        dly_d <= oai[if_d.stim];
    end
    assign if_c.dut_out = dly_c;
    assign if_d.dut_out = dly_d;

    // Indexed views of the four checkers
    logic       st  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       dn  [4];
    logic       bz  [4];
    logic       ps  [4];
    logic       fev [4];
    logic [3:0] ec  [4];
    logic [2:0] fei [4];
    logic [2:0] stm [4];
    logic [7:0] ott [4];

    assign if_a.start = st[0];
    assign if_b.start = st[1];
    assign if_c.start = st[2];
    assign if_d.start = st[3];

    always_comb begin
        dn[0] = if_a.done; bz[0] = if_a.busy; ps[0] = if_a.pass; fev[0] = if_a.first_err_valid;
        ec[0] = if_a.err_cnt; fei[0] = if_a.first_err_idx; stm[0] = if_a.stim; ott[0] = if_a.obs_tt;
        dn[1] = if_b.done; bz[1] = if_b.busy; ps[1] = if_b.pass; fev[1] = if_b.first_err_valid;
        ec[1] = if_b.err_cnt; fei[1] = if_b.first_err_idx; stm[1] = if_b.stim; ott[1] = if_b.obs_tt;
        dn[2] = if_c.done; bz[2] = if_c.busy; ps[2] = if_c.pass; fev[2] = if_c.first_err_valid;
        ec[2] = if_c.err_cnt; fei[2] = if_c.first_err_idx; stm[2] = if_c.stim; ott[2] = if_c.obs_tt;
        dn[3] = if_d.done; bz[3] = if_d.busy; ps[3] = if_d.pass; fev[3] = if_d.first_err_valid;
        ec[3] = if_d.err_cnt; fei[3] = if_d.first_err_idx; stm[3] = if_d.stim; ott[3] = if_d.obs_tt;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // What the checker should see at each sample: a late cell with no settle
    // time shows the previous vector's response (vector 0 follows stim 0 in idle)
    function automatic logic [7:0] model_obs(input logic [7:0] resp, input int settle, input bit late);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) begin
            o[i] = (late && settle == 0 && i > 0) ? resp[i-1] : resp[i];
        end
        return o;
    endfunction

    task automatic check_all_zero(input int k);
        check_eq("rst_stim", 32'(stm[k]), 0);
        check_eq("rst_busy", 32'(bz[k]), 0);
        check_eq("rst_done", 32'(dn[k]), 0);
        check_eq("rst_pass", 32'(ps[k]), 0);
        check_eq("rst_err_cnt", 32'(ec[k]), 0);
        check_eq("rst_fev", 32'(fev[k]), 0);
        check_eq("rst_fei", 32'(fei[k]), 0);
        check_eq("rst_obs_tt", 32'(ott[k]), 0);
    endtask

    // One sweep on checker k, checked cycle by cycle and at its done pulse
    task automatic run_sweep(input int k, input int settle, input logic [7:0] exp_tt,
                             input logic [7:0] resp, input bit late);
        logic [7:0] obs;
        int         err;
        int         first;
        int         cyc;
        obs   = model_obs(resp, settle, late);
        err   = $countones(obs ^ exp_tt);
        first = 0;
        for (int i = 7; i >= 0; i--) if (obs[i] != exp_tt[i]) first = i;
        if (k == 0) resp_a = resp;
        @(negedge clk);
        st[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[k] = 1'b0;
        cyc = 1;
        check_eq("clr_err_cnt", 32'(ec[k]), 0);
        check_eq("clr_obs_tt", 32'(ott[k]), 0);
        while (dn[k] !== 1'b1 && cyc < 400) begin
            check_eq("sweep_busy", 32'(bz[k]), 1);
            check_eq("sweep_stim", 32'(stm[k]), 32'((cyc - 1) / (settle + 1)));
            @(negedge clk);
            cyc++;
        end
        check_eq("done_cycle", 32'(cyc), 32'(1 + 8 * (settle + 1)));
        check_eq("done_busy", 32'(bz[k]), 0);
        check_eq("done_stim", 32'(stm[k]), 0);
        check_eq("obs_tt", 32'(ott[k]), 32'(obs));
        check_eq("err_cnt", 32'(ec[k]), 32'(err));
        check_eq("pass", 32'(ps[k]), 32'(err == 0));
        check_eq("first_err_valid", 32'(fev[k]), 32'(err != 0));
        check_eq("first_err_idx", 32'(fei[k]), 32'(first));
        @(negedge clk);
        check_eq("done_pulse_end", 32'(dn[k]), 0);
        check_eq("hold_err_cnt", 32'(ec[k]), 32'(err));
    endtask

    initial begin
        int cyc;
        logic [7:0] r;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) check_all_zero(k);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: good OAI21, stuck-at-0, wrong expected table, late cell
        run_sweep(0, 2, 8'h1F, TT_OAI21, 1'b0);
        run_sweep(0, 2, 8'h1F, 8'h00, 1'b0);
        run_sweep(1, 2, 8'h3F, TT_OAI21, 1'b0);
        run_sweep(2, 0, 8'h1F, TT_OAI21, 1'b1);
        run_sweep(3, 1, 8'h1F, TT_OAI21, 1'b1);

        // Random cell responses against the default checker
        for (int n = 0; n < 6; n++) begin
            r = 8'($urandom);
            run_sweep(0, 2, 8'h1F, r, 1'b0);
        end

        // Reset in cycle 10 of a stuck-at-0 sweep
        resp_a = 8'h00;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre_rst_err_cnt", 32'(ec[0]), 3);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero(0);
        rst = 1'b0;
        run_sweep(0, 2, 8'h1F, TT_OAI21, 1'b0);

        // Start held high: mid-sweep start ignored, back-to-back from done
        resp_a = 8'h00;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (dn[0] !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("held_done_cycle", 32'(cyc), 25);
        check_eq("held_err_cnt", 32'(ec[0]), 5);
        check_eq("held_pass", 32'(ps[0]), 0);
        @(negedge clk);
        check_eq("b2b_busy", 32'(bz[0]), 1);
        check_eq("b2b_stim", 32'(stm[0]), 0);
        check_eq("b2b_err_cnt", 32'(ec[0]), 0);
        check_eq("b2b_obs_tt", 32'(ott[0]), 0);
        check_eq("b2b_fev", 32'(fev[0]), 0);
        st[0] = 1'b0;
        resp_a = TT_OAI21;
        cyc = 1;
        while (dn[0] !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("b2b_done_cycle", 32'(cyc), 25);
        check_eq("b2b_final_err", 32'(ec[0]), 0);
        check_eq("b2b_final_pass", 32'(ps[0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
